// File: rtl/ir_pkg.sv
// Shared definitions for the IR transmit path.
// Contents: letter width, default letter-buffer depth and the
// scheduler state type.
package ir_pkg;

  localparam int LETTER_W          = 5;
  localparam int DEFAULT_BUF_DEPTH = 1000;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    WAIT_BUSY,
    WAIT_DONE,
    RETIRE
  } tx_sched_state_t;

endpackage

// File: rtl/ir_tx_scheduler_if.sv
// Letter-buffer BRAM connection between the scheduler and the simple
// dual-port BRAM in top level (same clock on both ports).
//   bram_wr_en_out   : port A write enable
//   bram_wr_addr_out : port A address (AW bits)
//   bram_wr_data_out : port A write data (letter)
//   bram_rd_addr_out : port B address (AW bits)
//   bram_rd_data_in  : port B read data (letter)
// master = scheduler side, slave = BRAM side.
interface ir_tx_scheduler_if #(
  parameter int AW = 10
);
  import ir_pkg::*;

  logic                bram_wr_en_out;
  logic [AW-1:0]       bram_wr_addr_out;
  logic [LETTER_W-1:0] bram_wr_data_out;
  logic [AW-1:0]       bram_rd_addr_out;
  logic [LETTER_W-1:0] bram_rd_data_in;

  modport master (
    output bram_wr_en_out,
    output bram_wr_addr_out,
    output bram_wr_data_out,
    output bram_rd_addr_out,
    input  bram_rd_data_in
  );

  modport slave (
    input  bram_wr_en_out,
    input  bram_wr_addr_out,
    input  bram_wr_data_out,
    input  bram_rd_addr_out,
    output bram_rd_data_in
  );

endinterface

// File: rtl/ir_tx_scheduler.sv
// Queue controller between the enigma encoder and the IR transmitter.
// Owns the letter-buffer BRAM pointers, writes each encoded letter, then
// reads letters back in order and hands them to the transmitter one at a
// time, waiting for each transmission to finish.
// Ports:
//   clk_in, rst_in   : clock, async active-high reset
//   flush_in         : discard all queued letters
//   wr_valid_in/data : new encoded letter (single-cycle pulse)
//   bram             : letter-buffer BRAM connection (master side)
//   tx_valid_out     : one-cycle send pulse to the transmitter
//   tx_data_out      : letter being sent, held until the next fetch
//   tx_busy_in       : transmitter busy
//   count_out, empty_out, full_out : queue occupancy
//   overflow_out     : sticky, a write was dropped while full
//   timeout_out      : sticky, busy never rose after a send
//
// state     | meaning
// IDLE      | wait for a queued letter
// FETCH     | wait out BRAM read latency, then capture the letter
// SEND      | one-cycle tx_valid_out pulse, arm busy timeout
// WAIT_BUSY | wait for transmitter to go busy (or time out)
// WAIT_DONE | wait for transmitter to finish
// RETIRE    | advance read pointer, release the entry
module ir_tx_scheduler
  import ir_pkg::*;
#(
  parameter int  DEPTH        = DEFAULT_BUF_DEPTH,
  parameter int  RD_LATENCY   = 2,
  parameter int  BUSY_TIMEOUT = 8,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                flush_in,
  input  logic                wr_valid_in,
  input  logic [LETTER_W-1:0] wr_data_in,
  ir_tx_scheduler_if.master   bram,
  output logic                tx_valid_out,
  output logic [LETTER_W-1:0] tx_data_out,
  input  logic                tx_busy_in,
  output logic [AW:0]         count_out,
  output logic                empty_out,
  output logic                full_out,
  output logic                overflow_out,
  output logic                timeout_out
);

  localparam int LAT_W = $clog2(RD_LATENCY + 1);
  localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);

  tx_sched_state_t state, state_nxt;

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [LAT_W-1:0] lat_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             wr_accept;
  logic             lat_load, to_load, capture, retire, timeout_set;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // full is judged on the registered count, so a write landing in the same
  // cycle as RETIRE on a full queue is still dropped
  assign empty_out = (count == '0);
  assign full_out  = (count == (AW+1)'(DEPTH));
  assign count_out = count;
  assign wr_accept = wr_valid_in && !full_out;

  assign bram.bram_wr_en_out   = wr_accept;
  assign bram.bram_wr_addr_out = wr_ptr;
  assign bram.bram_wr_data_out = wr_accept ? wr_data_in : '0;
  assign bram.bram_rd_addr_out = rd_ptr;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    lat_load     = 1'b0;
    to_load      = 1'b0;
    capture      = 1'b0;
    retire       = 1'b0;
    timeout_set  = 1'b0;
    tx_valid_out = 1'b0;
    case (state)
      IDLE: begin
        if (!empty_out) begin
          state_nxt = FETCH;
          lat_load  = 1'b1;
        end
      end
      FETCH: begin
        // counter reaches 0 on this cycle: read data is valid now
        if (lat_cnt <= LAT_W'(1)) begin
          capture   = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        tx_valid_out = 1'b1;
        to_load      = 1'b1;
        state_nxt    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy_in) begin
          state_nxt = WAIT_DONE;
        end else if (to_cnt <= TO_W'(1)) begin
          timeout_set = 1'b1;
          state_nxt   = RETIRE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy_in) state_nxt = RETIRE;
      end
      RETIRE: begin
        retire    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // a flush abandons whatever letter is in flight
    if (flush_in) begin
      state_nxt    = IDLE;
      tx_valid_out = 1'b0;
      lat_load     = 1'b0;
      to_load      = 1'b0;
      capture      = 1'b0;
      retire       = 1'b0;
      timeout_set  = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      lat_cnt      <= '0;
      to_cnt       <= '0;
      tx_data_out  <= '0;
      overflow_out <= 1'b0;
      timeout_out  <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= ptr_next(wr_ptr);

      if (flush_in) begin
        rd_ptr <= wr_ptr;
        count  <= {{AW{1'b0}}, wr_accept};
      end else begin
        if (retire) rd_ptr <= ptr_next(rd_ptr);
        if (wr_accept && !retire)      count <= count + 1'b1;
        else if (!wr_accept && retire) count <= count - 1'b1;
      end

      if (lat_load)                            lat_cnt <= LAT_W'(RD_LATENCY);
      else if (state == FETCH && lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;

      if (to_load)                                to_cnt <= TO_W'(BUSY_TIMEOUT);
      else if (state == WAIT_BUSY && to_cnt != '0) to_cnt <= to_cnt - 1'b1;

      if (capture) tx_data_out <= bram.bram_rd_data_in;

      if (wr_valid_in && full_out) overflow_out <= 1'b1;
      if (timeout_set)             timeout_out  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ir_tx_scheduler.sv
// Self-checking bench for ir_tx_scheduler (DEPTH overridden to 4 so that
// full/overflow and pointer wrap are reachable). Includes a read-latency
// BRAM model and a transmitter model that is busy for BUSY_LEN cycles
// after each send pulse; expected letters go into a scoreboard queue.
module tb_ir_tx_scheduler;
  import ir_pkg::*;

  localparam int DEPTH        = 4;
  localparam int RD_LATENCY   = 2;
  localparam int BUSY_TIMEOUT = 8;
  localparam int AW           = $clog2(DEPTH);
  localparam int BUSY_LEN     = 20;

  logic                clk_in      = 1'b0;
  logic                rst_in      = 1'b1;
  logic                flush_in    = 1'b0;
  logic                wr_valid_in = 1'b0;
  logic [LETTER_W-1:0] wr_data_in  = '0;
  logic                tx_valid_out;
  logic [LETTER_W-1:0] tx_data_out;
  logic                tx_busy_in;
  logic [AW:0]         count_out;
  logic                empty_out, full_out, overflow_out, timeout_out;

  ir_tx_scheduler_if #(.AW(AW)) bram_if ();

  ir_tx_scheduler #(
    .DEPTH       (DEPTH),
    .RD_LATENCY  (RD_LATENCY),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .flush_in    (flush_in),
    .wr_valid_in (wr_valid_in),
    .wr_data_in  (wr_data_in),
    .bram        (bram_if),
    .tx_valid_out(tx_valid_out),
    .tx_data_out (tx_data_out),
    .tx_busy_in  (tx_busy_in),
    .count_out   (count_out),
    .empty_out   (empty_out),
    .full_out    (full_out),
    .overflow_out(overflow_out),
    .timeout_out (timeout_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // BRAM model: read-first, RD_LATENCY register stages on port B
  logic [LETTER_W-1:0] mem [DEPTH];
  logic [LETTER_W-1:0] rd_pipe [RD_LATENCY];
  always @(posedge clk_in) begin
    if (bram_if.bram_wr_en_out) mem[bram_if.bram_wr_addr_out] <= bram_if.bram_wr_data_out;
    rd_pipe[0] <= mem[bram_if.bram_rd_addr_out];
    for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_if.bram_rd_data_in = rd_pipe[RD_LATENCY-1];

  // transmitter model
  int   busy_cnt   = 0;
  logic hold_busy  = 1'b0;
  logic never_busy = 1'b0;
  always @(posedge clk_in) begin
    if (tx_valid_out && !never_busy) busy_cnt <= BUSY_LEN;
    else if (busy_cnt > 0)           busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy_in = hold_busy || (busy_cnt > 0);

  // scoreboard
  logic [LETTER_W-1:0] exp_q [$];
  logic [LETTER_W-1:0] mon_exp;
  logic [AW-1:0]       exp_wr_ptr = '0;
  int vectors = 0, miscompares = 0;
  int n_pulses = 0, last_pulse_cyc = -1, last_wr_cyc = 0;

  always @(negedge clk_in) begin
    if (!rst_in && tx_valid_out) begin
      n_pulses++;
      last_pulse_cyc = cyc;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: got letter %0d at cycle %0d, required no pulse", tx_data_out, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (tx_data_out !== mon_exp) begin
          miscompares++;
          $display("FAIL tx_data: got %0d, required %0d", tx_data_out, mon_exp);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk_in);
    #2;
  endtask

  task automatic do_write(input logic [LETTER_W-1:0] d, input bit exp_accept,
                          input bit push, input bit with_flush);
    step();
    wr_valid_in = 1'b1;
    wr_data_in  = d;
    flush_in    = with_flush;
    last_wr_cyc = cyc;
    #1;
    vectors++;
    if (bram_if.bram_wr_en_out !== exp_accept) begin
      miscompares++;
      $display("FAIL wr_en: letter %0d got %0b, required %0b", d, bram_if.bram_wr_en_out, exp_accept);
    end
    if (exp_accept) begin
      vectors++;
      if (bram_if.bram_wr_addr_out !== exp_wr_ptr || bram_if.bram_wr_data_out !== d) begin
        miscompares++;
        $display("FAIL wr_addr_data: got addr %0d data %0d, required addr %0d data %0d",
                 bram_if.bram_wr_addr_out, bram_if.bram_wr_data_out, exp_wr_ptr, d);
      end
      exp_wr_ptr = (exp_wr_ptr == AW'(DEPTH - 1)) ? '0 : exp_wr_ptr + 1'b1;
      if (push) exp_q.push_back(d);
    end
    @(posedge clk_in);
    #1;
    wr_valid_in = 1'b0;
    flush_in    = 1'b0;
  endtask

  task automatic wait_pulse(input int start, output int pc);
    for (int i = 0; i < 80 && n_pulses == start; i++) step();
    vectors++;
    if (n_pulses == start) begin
      miscompares++;
      $display("FAIL pulse_wait: got no tx_valid_out in 80 cycles, required pulse %0d", start + 1);
    end
    pc = last_pulse_cyc;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && !(empty_out && exp_q.size() == 0); i++) step();
    repeat (2) step();
    vectors++;
    if (empty_out !== 1'b1 || count_out !== '0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got empty %0b count %0d with %0d letters unsent, required empty 1 count 0 none unsent",
               empty_out, count_out, exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_in);
    vectors++;
    if ({count_out, empty_out, full_out, tx_valid_out, tx_data_out, overflow_out, timeout_out,
         bram_if.bram_rd_addr_out, bram_if.bram_wr_en_out, bram_if.bram_wr_addr_out}
        !== {(AW+1)'(0), 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, AW'(0), 1'b0, AW'(0)}) begin
      miscompares++;
      $display("FAIL reset_state: got count %0d empty %0b full %0b valid %0b data %0d ovf %0b to %0b rd %0d, required 0 1 0 0 0 0 0 0",
               count_out, empty_out, full_out, tx_valid_out, tx_data_out, overflow_out, timeout_out,
               bram_if.bram_rd_addr_out);
    end
    rst_in = 1'b0;
  endtask

  task automatic test_three_letters();
    int s, w0, p0, p1, p2;
    s = n_pulses;
    do_write(5'd2, 1, 1, 0);
    w0 = last_wr_cyc;
    do_write(5'd0, 1, 1, 0);
    do_write(5'd19, 1, 1, 0);
    vectors++;
    if (count_out !== (AW+1)'(3)) begin
      miscompares++;
      $display("FAIL three_count: got %0d, required 3", count_out);
    end
    wait_pulse(s, p0);
    vectors++;
    if (p0 != w0 + RD_LATENCY + 2) begin
      miscompares++;
      $display("FAIL first_latency: got pulse at cycle %0d, required %0d", p0, w0 + RD_LATENCY + 2);
    end
    wait_pulse(s + 1, p1);
    wait_pulse(s + 2, p2);
    vectors++;
    if (p1 - p0 != BUSY_LEN + RD_LATENCY + 4 || p2 - p1 != BUSY_LEN + RD_LATENCY + 4) begin
      miscompares++;
      $display("FAIL letter_spacing: got %0d and %0d cycles, required %0d", p1 - p0, p2 - p1,
               BUSY_LEN + RD_LATENCY + 4);
    end
    drain();
    vectors++;
    if (n_pulses - s != 3) begin
      miscompares++;
      $display("FAIL three_pulses: got %0d pulses, required 3", n_pulses - s);
    end
  endtask

  task automatic test_overflow();
    int s;
    s = n_pulses;
    hold_busy = 1'b1;
    for (int i = 1; i <= 4; i++) do_write(LETTER_W'(i), 1, 1, 0);
    vectors++;
    if (full_out !== 1'b1 || count_out !== (AW+1)'(DEPTH) || overflow_out !== 1'b0) begin
      miscompares++;
      $display("FAIL full: got full %0b count %0d ovf %0b, required full 1 count %0d ovf 0",
               full_out, count_out, overflow_out, DEPTH);
    end
    do_write(5'd5, 0, 0, 0);
    vectors++;
    if (overflow_out !== 1'b1 || count_out !== (AW+1)'(DEPTH)) begin
      miscompares++;
      $display("FAIL overflow: got ovf %0b count %0d, required ovf 1 count %0d", overflow_out, count_out, DEPTH);
    end
    hold_busy = 1'b0;
    drain();
    vectors++;
    if (n_pulses - s != 4) begin
      miscompares++;
      $display("FAIL overflow_pulses: got %0d pulses, required 4", n_pulses - s);
    end
  endtask

  task automatic test_write_at_retire();
    int s, p, p2;
    s = n_pulses;
    do_write(5'd10, 1, 1, 0);
    wait_pulse(s, p);
    for (int i = 0; i < 60 && cyc < p + BUSY_LEN + 1; i++) step();
    vectors++;
    if (count_out !== (AW+1)'(1)) begin
      miscompares++;
      $display("FAIL pre_retire_count: got %0d, required 1", count_out);
    end
    do_write(5'd11, 1, 1, 0);
    vectors++;
    if (count_out !== (AW+1)'(1)) begin
      miscompares++;
      $display("FAIL coincident_count: got %0d, required 1", count_out);
    end
    wait_pulse(s + 1, p2);
    vectors++;
    if (p2 - p != BUSY_LEN + RD_LATENCY + 4) begin
      miscompares++;
      $display("FAIL coincident_next: got spacing %0d, required %0d", p2 - p, BUSY_LEN + RD_LATENCY + 4);
    end
    drain();
  endtask

  task automatic test_timeout();
    int s, p, p2;
    s = n_pulses;
    never_busy = 1'b1;
    do_write(5'd20, 1, 1, 0);
    do_write(5'd21, 1, 1, 0);
    wait_pulse(s, p);
    for (int i = 0; i < 40 && cyc < p + BUSY_TIMEOUT; i++) step();
    vectors++;
    if (timeout_out !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early: got %0b at %0d cycles after send, required 0", timeout_out, cyc - p);
    end
    step();
    vectors++;
    if (timeout_out !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_set: got %0b at %0d cycles after send, required 1", timeout_out, cyc - p);
    end
    wait_pulse(s + 1, p2);
    vectors++;
    if (p2 - p != BUSY_TIMEOUT + RD_LATENCY + 3) begin
      miscompares++;
      $display("FAIL timeout_next: got spacing %0d, required %0d", p2 - p, BUSY_TIMEOUT + RD_LATENCY + 3);
    end
    drain();
    never_busy = 1'b0;
  endtask

  task automatic test_flush();
    int s, p;
    s = n_pulses;
    do_write(5'd12, 1, 1, 0);
    do_write(5'd13, 1, 0, 0);
    do_write(5'd14, 1, 0, 0);
    wait_pulse(s, p);
    for (int i = 0; i < 20 && cyc < p + 5; i++) step();
    vectors++;
    if (count_out !== (AW+1)'(3)) begin
      miscompares++;
      $display("FAIL preflush_count: got %0d, required 3", count_out);
    end
    flush_in = 1'b1;
    @(posedge clk_in);
    #1;
    flush_in = 1'b0;
    vectors++;
    if (count_out !== '0 || empty_out !== 1'b1 || bram_if.bram_rd_addr_out !== exp_wr_ptr) begin
      miscompares++;
      $display("FAIL flush: got count %0d empty %0b rd %0d, required count 0 empty 1 rd %0d",
               count_out, empty_out, bram_if.bram_rd_addr_out, exp_wr_ptr);
    end
    repeat (40) step();
    vectors++;
    if (n_pulses - s != 1) begin
      miscompares++;
      $display("FAIL flush_pulses: got %0d pulses, required 1", n_pulses - s);
    end
    do_write(5'd7, 1, 1, 0);
    drain();
    do_write(5'd9, 1, 1, 1);
    vectors++;
    if (count_out !== (AW+1)'(1)) begin
      miscompares++;
      $display("FAIL flush_with_write: got count %0d, required 1", count_out);
    end
    drain();
    vectors++;
    if (overflow_out !== 1'b1 || timeout_out !== 1'b1) begin
      miscompares++;
      $display("FAIL sticky: got ovf %0b to %0b, required 1 1", overflow_out, timeout_out);
    end
  endtask

  task automatic test_async_reset();
    int s;
    s = n_pulses;
    do_write(5'd15, 1, 0, 0);
    @(posedge clk_in);
    #3;
    rst_in = 1'b1;
    #1;
    vectors++;
    if ({count_out, empty_out, full_out, tx_valid_out, tx_data_out, overflow_out, timeout_out,
         bram_if.bram_rd_addr_out, bram_if.bram_wr_en_out, bram_if.bram_wr_addr_out}
        !== {(AW+1)'(0), 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, AW'(0), 1'b0, AW'(0)}) begin
      miscompares++;
      $display("FAIL async_reset: got count %0d empty %0b full %0b valid %0b data %0d ovf %0b to %0b rd %0d, required 0 1 0 0 0 0 0 0",
               count_out, empty_out, full_out, tx_valid_out, tx_data_out, overflow_out, timeout_out,
               bram_if.bram_rd_addr_out);
    end
    exp_wr_ptr = '0;
    repeat (3) step();
    rst_in = 1'b0;
    repeat (20) step();
    vectors++;
    if (n_pulses != s || empty_out !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset: got %0d pulses empty %0b, required 0 pulses empty 1", n_pulses - s, empty_out);
    end
  endtask

  initial begin
    test_reset();
    test_three_letters();
    test_overflow();
    test_write_at_retire();
    test_timeout();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200000 ns, required completion");
    $fatal(1);
  end

endmodule

// File: doc/ir_tx_scheduler.md
Name: ir_tx_scheduler

Overview:
- Queue controller between the enigma encoder output and the IR transmitter.
- Owns the write/read pointers of the 5-bit-wide, DEPTH-entry letter buffer BRAM (simple dual port, same clock).
- Each encoded letter is written into the BRAM. Letters are read back in order and handed to the transmitter one at a time, with one valid pulse per letter, waiting for each transmission to finish.
- Replaces ad-hoc pointer and valid-pipe logic in top level; runs on clk_100_passthrough.

Parameters:
- DEPTH, 1000, number of BRAM entries; pointers wrap DEPTH-1 -> 0.
- RD_LATENCY, 2, BRAM read latency in cycles (HIGH_PERFORMANCE = 2).
- BUSY_TIMEOUT, 8, max cycles to wait for tx_busy_in to rise after a send pulse.
- AW, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset.
- flush_in  input  1  synchronous pulse: discard queued letters.
- wr_valid_in  input  1  single-cycle pulse: new encoded letter.
- wr_data_in  input  5  letter 0-25.
- bram_wr_en_out  output  1  BRAM port A write enable.
- bram_wr_addr_out  output  AW  BRAM port A address.
- bram_wr_data_out  output  5  BRAM port A data.
- bram_rd_addr_out  output  AW  BRAM port B address.
- bram_rd_data_in  input  5  BRAM port B data.
- tx_valid_out  output  1  single-cycle pulse to ir_transmitter data_valid_in.
- tx_data_out  output  5  letter to transmit; held stable from pulse until done.
- tx_busy_in  input  1  ir_transmitter busy_out.
- count_out  output  AW+1  occupied entries, 0..DEPTH.
- empty_out  output  1  count_out==0.
- full_out  output  1  count_out==DEPTH.
- overflow_out  output  1  sticky: a write was dropped.
- timeout_out  output  1  sticky: busy never rose after a send.

Behaviour:
- Clock and reset (already decided): one clock, clk_in; rst_in is asynchronous, active-high.
- Reset values:
  - Pointers, count_out, bram_* outputs, tx_valid_out, tx_data_out, overflow_out and timeout_out all 0.
  - empty_out=1, full_out=0, state IDLE.
- Write path:
  - When wr_valid_in is high and not full, drive bram_wr_en_out=1 the same cycle (combinational passthrough of the write).
  - In that write, addr=wr_ptr and data=wr_data_in; wr_ptr advances with wrap.
  - If full, the write is dropped (bram_wr_en_out=0) and overflow_out is set.
- bram_rd_addr_out = rd_ptr, registered.
- FSM states:
  - IDLE: if !empty, go to FETCH and load the latency counter with RD_LATENCY.
  - FETCH: decrement the counter; when it hits 0, capture bram_rd_data_in into tx_data_out and go to SEND.
  - SEND: tx_valid_out=1 for exactly this cycle; load the timeout counter; go to WAIT_BUSY.
  - WAIT_BUSY:
    - tx_busy_in=1 -> WAIT_DONE.
    - Timeout counter expiry -> set timeout_out and go to RETIRE (letter treated as sent).
  - WAIT_DONE: tx_busy_in=0 -> RETIRE.
  - RETIRE: rd_ptr advances with wrap; count decrements; go to IDLE.
- Minimum per-letter turnaround: IDLE to next FETCH is 1 cycle after RETIRE.
- Count update:
  - +1 on an accepted write, -1 on RETIRE.
  - A simultaneous accepted write and RETIRE leaves count unchanged.
  - A write while full in the same cycle as RETIRE is still dropped, because full is evaluated on the registered count.
- Hazard: the read slot is always occupied (count>0) and the write slot differs from it, so BRAM read-first collisions cannot occur.
- flush_in:
  - Sets rd_ptr:=wr_ptr and count:=0, and returns the FSM to IDLE.
  - tx_valid_out is forced to 0.
  - A transmission already in progress is not aborted in the transmitter, but its completion is ignored.
  - A wr_valid_in in the same cycle as flush is accepted after the flush (count=1).
- Sticky flags clear only on reset.
- tx_data_out holds its last value in IDLE.

Decomposition:
- Shared package (ir_pkg):
  - LETTER_W=5.
  - Enum tx_sched_state_t {IDLE, FETCH, SEND, WAIT_BUSY, WAIT_DONE, RETIRE}.
  - Constant DEFAULT_BUF_DEPTH=1000.
- Optional sub-module wrap_counter (param MAX, AW) for the two pointers; everything else is inline.
- The BRAM itself stays outside this block in top level.

Test Plan:
- Three writes (C=2, A=0, T=19) with transmitter model busy for 20 cycles each:
  - Exactly three tx_valid_out pulses with tx_data_out 2, 0, 19 in order.
  - Each pulse occurs RD_LATENCY+1 cycles after IDLE exit.
  - count_out goes 3->0; empty_out=1 at end.
- DEPTH=4 override, five writes with busy held high:
  - full_out=1 after the fourth write; the fifth write is dropped and overflow_out=1.
  - After drain, letters 1-4 are transmitted.
  - Pointers wrap 3->0 correctly on a subsequent write.
- Write coincident with RETIRE at count=1: count_out stays 1 and the next letter is transmitted.
- Transmitter never asserts busy: timeout_out=1 after BUSY_TIMEOUT cycles, the letter is retired, and the next letter is sent.
- flush_in during WAIT_DONE with count=3: count_out=0 next cycle and no further tx_valid_out; a subsequent write of 7 is transmitted as 7.
- rst_in asserted asynchronously mid-FETCH: all outputs are 0 (empty_out=1) without waiting for a clock edge.
